data_mem_responder: RTL and testbench

- Responder (memory side) of the core's load/store port: accepts load/store requests carrying address, store data and funct3, and returns load data.
- Sits between the datapath's ALUResult/WriteData/ReadData interface and a word-organised RAM.
- Adds valid/ready handshaking, programmable wait states, byte/halfword lane handling with sign extension, and error reporting.

---
 rtl/data_mem_if.sv | 23 ++
 rtl/data_mem_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - load/store request/response bundle between core and data memory
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word RAM responder with wait states, byte lanes and error reporting
// Optional: define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of aligning them.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  data_mem_if.slave   bus
);

  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        idle;
  logic        accept;
  logic        enter_resp;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_f3;
  logic [31:0] off;
  logic [1:0]  lane;
  logic        in_range;
  logic        f3_ok;
  logic        misaligned;
  logic        req_err;
  logic [IDX_W-1:0] idx;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [3:0]  byte_en;
  logic [31:0] wr_lanes;
  logic        commit;

  assign idle   = (state_q == S_IDLE);
  assign accept = idle && bus.req_valid && !reset;

  // With zero wait states the response is built on the accept edge, so decode
  // must look at the live request rather than the not-yet-latched copy.
  always_comb begin
    cur_we    = idle ? bus.req_we     : we_q;
    cur_addr  = idle ? bus.req_addr   : addr_q;
    cur_wdata = idle ? bus.req_wdata  : wdata_q;
    cur_f3    = idle ? bus.req_funct3 : funct3_q;
  end

  always_comb begin
    off      = cur_addr - ADDR_BASE;
    in_range = (cur_addr >= ADDR_BASE) && (off[31:2] < DEPTH_L);
    idx      = off[IDX_W+1:2];

    if (cur_we) begin
      f3_ok = (cur_f3 == 3'b000) || (cur_f3 == 3'b001) || (cur_f3 == 3'b010);
    end else begin
      f3_ok = (cur_f3 == 3'b000) || (cur_f3 == 3'b001) || (cur_f3 == 3'b010) ||
              (cur_f3 == 3'b100) || (cur_f3 == 3'b101);
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    misaligned = ((cur_f3[1:0] == 2'b01) && off[0]) ||
                 ((cur_f3[1:0] == 2'b10) && (off[1:0] != 2'b00));
    lane       = off[1:0];
`else
    misaligned = 1'b0;
    case (cur_f3[1:0])
      2'b01:   lane = {off[1], 1'b0};
      2'b10:   lane = 2'b00;
      default: lane = off[1:0];
    endcase
`endif

    req_err = !in_range || !f3_ok || misaligned;
  end

  // Load extraction: pick the addressed lane(s), then extend per funct3.
  always_comb begin
    rd_word = mem[idx];
    case (lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (cur_f3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'd0, rd_byte};
      3'b101:  load_val = {16'd0, rd_half};
      default: load_val = 32'd0;
    endcase
  end

  always_comb begin
    case (cur_f3[1:0])
      2'b00: begin
        byte_en  = 4'b0001 << lane;
        wr_lanes = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        byte_en  = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{cur_wdata[15:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        wr_lanes = cur_wdata;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    enter_resp  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d     = bus.req_we;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          funct3_d = bus.req_funct3;
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_resp) begin
      state_d     = S_RESP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = req_err;
      rsp_rdata_d = (req_err || cur_we) ? 32'd0 : load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      funct3_q    <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Stores commit on the RESP-entry edge; a reset on that edge discards them.
  assign commit = enter_resp && cur_we && !req_err && !reset;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = idle && !reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  data_mem_if bus ();

  data_mem_responder #(
    .DEPTH_WORDS (256),
    .WAIT_CYCLES (1),
    .ADDR_BASE   (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_funct3 = f3;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_wdata  = 32'h0BAD_0BAD;
    lat = 1;
    while (!bus.rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] hold_rd;
  int          n;

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_funct3 = 3'd0;
    bus.rsp_ready  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata,          32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, lat);
    check("sw_err", {31'd0, er}, 32'd0);
    check("sw_rdata", rd, 32'd0);
    check("sw_latency", lat, 32'd2);
    do_req(1'b0, 32'h10, 32'd0, 3'b010, rd, er, lat);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_err", {31'd0, er}, 32'd0);
    check("lw_latency", lat, 32'd2);

    do_req(1'b1, 32'h12, 32'h0000007F, 3'b000, rd, er, lat);
    check("sb_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 32'h10, 32'd0, 3'b010, rd, er, lat);
    check("lw_after_sb", rd, 32'hDE7FBEEF);
    do_req(1'b0, 32'h13, 32'd0, 3'b000, rd, er, lat);
    check("lb_13", rd, 32'hFFFFFFDE);
    do_req(1'b0, 32'h13, 32'd0, 3'b100, rd, er, lat);
    check("lbu_13", rd, 32'h000000DE);
    do_req(1'b0, 32'h12, 32'd0, 3'b001, rd, er, lat);
    check("lh_12", rd, 32'hFFFFDE7F);
    do_req(1'b0, 32'h10, 32'd0, 3'b101, rd, er, lat);
    check("lhu_10", rd, 32'h0000BEEF);
    do_req(1'b1, 32'h14, 32'h0000_A5C3, 3'b001, rd, er, lat);
    do_req(1'b1, 32'h16, 32'h0000_1234, 3'b001, rd, er, lat);
    do_req(1'b0, 32'h14, 32'd0, 3'b010, rd, er, lat);
    check("sh_pair", rd, 32'h1234A5C3);

    // Backpressure: response must hold while rsp_ready is low.
    @(negedge clk);
    bus.rsp_ready  = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h10;
    bus.req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
    hold_rd = bus.rsp_rdata;
    check("stall_first", hold_rd, 32'hDE7FBEEF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("stall_hold_rdata", bus.rsp_rdata, 32'hDE7FBEEF);
      check("stall_hold_err", {31'd0, bus.rsp_err}, 32'd0);
      check("stall_ready_low", {31'd0, bus.req_ready}, 32'd0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("release_ready", {31'd0, bus.req_ready}, 32'd1);

    // Range and funct3 errors must not write anywhere.
    do_req(1'b1, 32'h3FC, 32'hCAFEF00D, 3'b010, rd, er, lat);
    do_req(1'b1, 32'h0, 32'h01020304, 3'b010, rd, er, lat);
    do_req(1'b0, 32'h400, 32'd0, 3'b010, rd, er, lat);
    check("oor_lw_err", {31'd0, er}, 32'd1);
    check("oor_lw_rdata", rd, 32'd0);
    do_req(1'b0, 32'h10, 32'd0, 3'b011, rd, er, lat);
    check("bad_f3_err", {31'd0, er}, 32'd1);
    check("bad_f3_rdata", rd, 32'd0);
    do_req(1'b1, 32'h400, 32'hFFFFFFFF, 3'b010, rd, er, lat);
    check("oor_sw_err", {31'd0, er}, 32'd1);
    do_req(1'b1, 32'h10, 32'h55555555, 3'b011, rd, er, lat);
    check("bad_sf3_err", {31'd0, er}, 32'd1);
    do_req(1'b0, 32'h3FC, 32'd0, 3'b010, rd, er, lat);
    check("lw_3fc", rd, 32'hCAFEF00D);
    check("lw_3fc_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 32'h0, 32'd0, 3'b010, rd, er, lat);
    check("lw_0_intact", rd, 32'h01020304);
    do_req(1'b0, 32'h10, 32'd0, 3'b010, rd, er, lat);
    check("lw_10_intact", rd, 32'hDE7FBEEF);

    // Reset during the wait state discards the pending store.
    do_req(1'b1, 32'h20, 32'hAAAAAAAA, 3'b010, rd, er, lat);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h12345678;
    bus.req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_req(1'b0, 32'h20, 32'd0, 3'b010, rd, er, lat);
    check("midrst_discard", rd, 32'hAAAAAAAA);

    do_req(1'b1, 32'h11, 32'h11223344, 3'b010, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("mis_sw_err", {31'd0, er}, 32'd1);
    do_req(1'b0, 32'h10, 32'd0, 3'b010, rd, er, lat);
    check("mis_mem_kept", rd, 32'hDE7FBEEF);
`else
    check("mis_sw_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 32'h10, 32'd0, 3'b010, rd, er, lat);
    check("mis_aligned_write", rd, 32'h11223344);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
